hilo_muldiv: RTL

- Multi-cycle multiply/divide unit with architectural HI/LO registers. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Sits in the execute stage beside the combinational ALU and shares its operand buses a/b.
- Produces a stall request so the pipeline freezes while an iterative operation runs.
- MFHI/MFLO read the hi/lo outputs directly.

---
 rtl/muldiv_pkg.sv | 28 ++
 rtl/muldiv_div_iter.sv | 67 ++++++
 rtl/hilo_muldiv.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit.
// Operation codes, FSM states and the default datapath width.
package muldiv_pkg;

  localparam int unsigned MD_WIDTH = 32;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv,
    StFix
  } md_state_e;

  // True for the iterative ops that must stall the pipeline.
  function automatic logic is_md_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_div_iter.sv
// Restoring unsigned divider, one quotient bit per cycle, WIDTH iterations.
// last_o is high in the cycle whose closing edge writes the final quotient/remainder.
module muldiv_div_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             resetn_i,
  input  logic             load_i,
  input  logic             cancel_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quot_o,
  output logic [WIDTH-1:0] rem_o,
  output logic             last_o
);

  localparam int unsigned CntW = $clog2(WIDTH);

  logic             run_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] divisor_q;
  logic [WIDTH:0]   shifted;
  logic             ge;

  // The quotient register starts as the dividend; its MSB feeds the remainder each step.
  always_comb begin
    shifted = {rem_q, quot_q[WIDTH-1]};
    ge      = shifted >= {1'b0, divisor_q};
    rem_d   = ge ? (shifted[WIDTH-1:0] - divisor_q) : shifted[WIDTH-1:0];
    quot_d  = {quot_q[WIDTH-2:0], ge};
  end

  assign last_o = run_q && (cnt_q == '0);
  assign quot_o = quot_q;
  assign rem_o  = rem_q;

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      run_q     <= 1'b0;
      cnt_q     <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      divisor_q <= '0;
    end else if (load_i) begin
      run_q     <= 1'b1;
      cnt_q     <= CntW'(WIDTH - 1);
      rem_q     <= '0;
      quot_q    <= dividend_i;
      divisor_q <= divisor_i;
    end else if (run_q) begin
      if (cancel_i) begin
        run_q <= 1'b0;
      end else begin
        rem_q  <= rem_d;
        quot_q <= quot_d;
        if (cnt_q == '0) begin
          run_q <= 1'b0;
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/hilo_muldiv.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Define MULDIV_FAST_MUL_EN for a single-cycle native multiplier; divide stays iterative.
module hilo_muldiv
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic             clk_i,
  input  logic             resetn_i,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cancel_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  md_state_e          state_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [2*WIDTH-1:0] mul_init;
  logic               neg_res_q, neg_rem_q, is_div_q, div_zero_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic               signed_op;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic               div_load;
  logic [WIDTH-1:0]   quot, rem;
  logic               div_last;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  assign signed_op = (op_i == MD_MULT) || (op_i == MD_DIV);
  assign abs_a     = (signed_op && a_i[WIDTH-1]) ? -a_i : a_i;
  assign abs_b     = (signed_op && b_i[WIDTH-1]) ? -b_i : b_i;
  assign div_load  = (state_q == StIdle) && start_i && !cancel_i &&
                     ((op_i == MD_DIV) || (op_i == MD_DIVU));

`ifdef MULDIV_FAST_MUL_EN
  assign mul_init = {{WIDTH{1'b0}}, abs_a} * {{WIDTH{1'b0}}, abs_b};
`else
  localparam int unsigned CntW = $clog2(WIDTH);

  logic [CntW-1:0]    cnt_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_d;

  // Accumulator holds {partial sum, unconsumed multiplier bits}; shift right each step.
  always_comb begin
    mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_d  = {mul_sum, prod_q[WIDTH-1:1]};
  end

  assign mul_init = {{WIDTH{1'b0}}, abs_b};
`endif

  muldiv_div_iter #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk_i     (clk_i),
    .resetn_i  (resetn_i),
    .load_i    (div_load),
    .cancel_i  (cancel_i),
    .dividend_i(abs_a),
    .divisor_i (abs_b),
    .quot_o    (quot),
    .rem_o     (rem),
    .last_o    (div_last)
  );

  // Sign correction applied to the unsigned magnitude results.
  always_comb begin
    fix_hi = prod_q[2*WIDTH-1:WIDTH];
    fix_lo = prod_q[WIDTH-1:0];
    if (is_div_q) begin
      fix_lo = neg_res_q ? -quot : quot;
      fix_hi = neg_rem_q ? -rem : rem;
      if (div_zero_q) begin
        fix_lo = '1;
      end
    end else if (neg_res_q) begin
      {fix_hi, fix_lo} = -prod_q;
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q    <= StIdle;
      prod_q     <= '0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      is_div_q   <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
`ifndef MULDIV_FAST_MUL_EN
      cnt_q      <= '0;
      mcand_q    <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i && !cancel_i) begin
            case (op_i)
              MD_MULT, MD_MULTU: begin
                prod_q    <= mul_init;
                neg_res_q <= signed_op && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                is_div_q  <= 1'b0;
`ifdef MULDIV_FAST_MUL_EN
                state_q   <= StFix;
`else
                mcand_q   <= abs_a;
                cnt_q     <= CntW'(WIDTH - 1);
                state_q   <= StMul;
`endif
              end
              MD_DIV, MD_DIVU: begin
                neg_res_q  <= signed_op && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                neg_rem_q  <= signed_op && a_i[WIDTH-1];
                is_div_q   <= 1'b1;
                div_zero_q <= (b_i == '0);
                state_q    <= StDiv;
              end
              MD_MTHI: hi_q <= a_i;
              MD_MTLO: lo_q <= a_i;
              default: ;
            endcase
          end
        end
        StMul: begin
`ifdef MULDIV_FAST_MUL_EN
          state_q <= StIdle;
`else
          if (cancel_i) begin
            state_q <= StIdle;
          end else begin
            prod_q <= prod_d;
            if (cnt_q == '0) begin
              state_q <= StFix;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
`endif
        end
        StDiv: begin
          if (cancel_i) begin
            state_q <= StIdle;
          end else if (div_last) begin
            state_q <= StFix;
          end
        end
        StFix: begin
          state_q <= StIdle;
          if (!cancel_i) begin
            hi_q <= fix_hi;
            lo_q <= fix_lo;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // busy drops in the fix cycle so the next instruction advances as the result lands.
  assign busy_o = (state_q == StMul) || (state_q == StDiv) || (start_i && is_md_op(op_i));
  assign done_o = (state_q == StFix) && !cancel_i;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule
